dcache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache for the ME stage of the 5-stage MIPS pipeline.
- Consumes the EX/ME latch outputs (address = ALU result, read/write strobes, store data). Returns load data plus a stall signal that freezes ID/EX, EX/ME and ME/WB.
- Talks to a slow word-wide backing memory over a req/ack handshake.

---
 rtl/dcache_ctrl_if.sv | 26 ++
 rtl/dcache_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: ME-stage load/store port and word-wide backing-memory handshake of dcache_ctrl.
// The slave modport is the cache's view; the master modport is the pipeline plus memory side.
interface dcache_ctrl_if;
  logic [31:0] addr;
  logic        rmem;
  logic        wmem;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  addr, rmem, wmem, wdata, mem_rdata, mem_ack,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output addr, rmem, wmem, wdata, mem_rdata, mem_ack,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache for the MIPS ME stage.
// Define DCACHE_STATS_EN to add the hit_count/miss_count load statistics outputs.
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic         clock,
  input  logic         reset,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int LOW    = 2 + OFF_W;
  localparam int TAG_LO = LOW + IDX_W;
  localparam int TAG_W  = 32 - TAG_LO;

  localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t             state_q;
  logic [OFF_W-1:0]   cnt_q;
  logic [OFF_W-1:0]   cnt_d;
  logic [LINES-1:0]   valid_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        mem_wdata_q;

  logic [31:0]        dataArr_q [LINES][WORDS];
  logic [TAG_W-1:0]   tagArr_q  [LINES];

  logic [OFF_W-1:0]   reqOff;
  logic [IDX_W-1:0]   reqIdx;
  logic [TAG_W-1:0]   reqTag;
  logic [OFF_W-1:0]   latOff;
  logic [IDX_W-1:0]   latIdx;
  logic [TAG_W-1:0]   latTag;

  logic               isStore;
  logic               isLoad;
  logic               hit;
  logic               latHit;
  logic               ackSeen;
  logic               lastWord;
  logic [31:0]        cachedWord;
  logic               stallComb;
  logic [31:0]        rdataComb;
  logic               unusedBits;

  assign reqOff = bus.addr[LOW-1:2];
  assign reqIdx = bus.addr[TAG_LO-1:LOW];
  assign reqTag = bus.addr[31:TAG_LO];

  // The transaction in flight is identified by the registered memory address.
  assign latOff = mem_addr_q[LOW-1:2];
  assign latIdx = mem_addr_q[TAG_LO-1:LOW];
  assign latTag = mem_addr_q[31:TAG_LO];

  assign isStore    = bus.wmem;
  assign isLoad     = bus.rmem & ~bus.wmem;
  assign hit        = valid_q[reqIdx] && (tagArr_q[reqIdx] == reqTag);
  assign latHit     = valid_q[latIdx] && (tagArr_q[latIdx] == latTag);
  assign cachedWord = dataArr_q[reqIdx][reqOff];
  assign ackSeen    = bus.mem_ack & mem_req_q;
  assign lastWord   = (cnt_q == CNT_LAST);
  assign cnt_d      = cnt_q + CNT_ONE;
  assign unusedBits = &{1'b0, bus.addr[1:0], mem_addr_q[1:0]};

  always_comb begin
    stallComb = 1'b0;
    rdataComb = '0;
    case (state_q)
      IDLE: begin
        if (isStore) begin
          stallComb = 1'b1;
        end else if (isLoad) begin
          if (hit) rdataComb = cachedWord;
          else     stallComb = 1'b1;
        end
      end
      FILL, WRITE: stallComb = 1'b1;
      DONE: begin
        if (isLoad) rdataComb = cachedWord;
      end
      default: stallComb = 1'b0;
    endcase
  end

  // Control FSM; a late ack with mem_req low is filtered out by ackSeen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (isStore) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {bus.addr[31:2], 2'b00};
            mem_wdata_q <= bus.wdata;
            state_q     <= WRITE;
          end else if (isLoad && !hit) begin
            mem_req_q       <= 1'b1;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= {bus.addr[31:LOW], {LOW{1'b0}}};
            cnt_q           <= '0;
            valid_q[reqIdx] <= 1'b0;
            state_q         <= FILL;
          end
        end
        FILL: begin
          if (ackSeen) begin
            cnt_q <= cnt_d;
            if (lastWord) begin
              valid_q[latIdx] <= 1'b1;
              mem_req_q       <= 1'b0;
              state_q         <= DONE;
            end else begin
              mem_addr_q <= {mem_addr_q[31:LOW], cnt_d, 2'b00};
            end
          end
        end
        WRITE: begin
          if (ackSeen) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Arrays carry no reset; validity alone decides whether a line may hit.
  always_ff @(posedge clock) begin
    if (state_q == FILL && ackSeen) begin
      dataArr_q[latIdx][cnt_q] <= bus.mem_rdata;
      if (lastWord) tagArr_q[latIdx] <= latTag;
    end else if (state_q == WRITE && ackSeen && latHit) begin
      dataArr_q[latIdx][latOff] <= mem_wdata_q;
    end
  end

  assign bus.stall     = stallComb;
  assign bus.rdata     = rdataComb;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hitCount_q;
  logic [31:0] missCount_q;

  // A hit finishes in its IDLE cycle and a miss leaves IDLE immediately, so each load counts once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else if (state_q == IDLE && isLoad) begin
      if (hit) hitCount_q  <= hitCount_q + 32'd1;
      else     missCount_q <= missCount_q + 32'd1;
    end
  end

  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table-driven directed vectors for dcache_ctrl against a word-addressed memory model,
// plus hand-written reset-during-fill, late-ack and (with DCACHE_STATS_EN) statistics sequences.
module tb_dcache_ctrl;
  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic clock;
  logic reset;
  int   vecCount;
  int   errCount;

  dcache_ctrl_if cacheBus();

`ifdef DCACHE_STATS_EN
  logic [31:0] hitCount;
  logic [31:0] missCount;
`endif

  dcache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (cacheBus.slave)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hitCount),
    .miss_count (missCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        isLoad;
    logic        isStore;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    int          expStall;
    logic [31:0] expRdata;
    int          expReads;
    int          expWrites;
    logic [31:0] expFirst;
  } vec_t;

  typedef struct {
    logic        done;
    int          stallCyc;
    logic [31:0] rdata;
    int          reads;
    int          writes;
    logic [31:0] first;
    logic        seqOk;
    logic [31:0] lastWdata;
  } res_t;

  logic [31:0] memStore [logic [31:0]];

  // Untouched words read as 0xA0 + word-in-line plus the address bits above the index.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memStore.exists(a)) return memStore[a];
    return 32'hA0 + {30'h0, a[3:2]} + (a & 32'hFFFF_FF00);
  endfunction

  function automatic vec_t mk(input string n, input logic ld, input logic st,
                              input logic [31:0] a, input logic [31:0] wd, input int w,
                              input int es, input logic [31:0] er, input int nr,
                              input int nw, input logic [31:0] ef);
    vec_t v;
    v.name = n; v.isLoad = ld; v.isStore = st; v.addr = a; v.wdata = wd; v.waits = w;
    v.expStall = es; v.expRdata = er; v.expReads = nr; v.expWrites = nw; v.expFirst = ef;
    return v;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Call at a negedge; holds the request until the cycle with stall low has been clocked.
  task automatic applyStimulus(input vec_t v, output res_t r);
    int waitCnt;
    r.done = 1'b0; r.stallCyc = 0; r.rdata = '0; r.reads = 0; r.writes = 0;
    r.first = '0; r.seqOk = 1'b1; r.lastWdata = '0;
    waitCnt = 0;
    cacheBus.addr  = v.addr;
    cacheBus.wdata = v.wdata;
    cacheBus.rmem  = v.isLoad;
    cacheBus.wmem  = v.isStore;
    for (int cyc = 0; cyc < 200 && !r.done; cyc++) begin
      #1;
      cacheBus.mem_ack = 1'b0;
      if (cacheBus.mem_req) begin
        if (waitCnt == v.waits) begin
          waitCnt = 0;
          cacheBus.mem_ack = 1'b1;
          if (r.reads + r.writes == 0) r.first = cacheBus.mem_addr;
          if (cacheBus.mem_we) begin
            memStore[cacheBus.mem_addr] = cacheBus.mem_wdata;
            r.lastWdata = cacheBus.mem_wdata;
            r.writes++;
          end else begin
            if (cacheBus.mem_addr !== r.first + 32'(4 * r.reads)) r.seqOk = 1'b0;
            cacheBus.mem_rdata = memRead(cacheBus.mem_addr);
            r.reads++;
          end
        end else begin
          waitCnt++;
        end
      end
      #1;
      if (cacheBus.stall) r.stallCyc++;
      else begin
        r.done  = 1'b1;
        r.rdata = cacheBus.rdata;
      end
      @(posedge clock);
      @(negedge clock);
    end
    cacheBus.rmem    = 1'b0;
    cacheBus.wmem    = 1'b0;
    cacheBus.mem_ack = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input res_t r);
    checkVal({v.name, " complete"}, 32'(r.done), 32'd1);
    checkVal({v.name, " stall cycles"}, r.stallCyc, v.expStall);
    if (!v.isStore) checkVal({v.name, " rdata"}, r.rdata, v.expRdata);
    checkVal({v.name, " reads"}, r.reads, v.expReads);
    checkVal({v.name, " writes"}, r.writes, v.expWrites);
    if (v.expReads + v.expWrites > 0) checkVal({v.name, " first mem_addr"}, r.first, v.expFirst);
    if (v.expReads > 0) checkVal({v.name, " fill address order"}, 32'(r.seqOk), 32'd1);
    if (v.expWrites > 0) checkVal({v.name, " mem_wdata"}, r.lastWdata, v.wdata);
  endtask

  task automatic runOne(input vec_t v);
    res_t r;
    applyStimulus(v, r);
    checkOutput(v, r);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, %0d vectors applied", vecCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [18];
    int   ackCnt;

    vecCount = 0;
    errCount = 0;
    cacheBus.addr = '0; cacheBus.rmem = 1'b0; cacheBus.wmem = 1'b0; cacheBus.wdata = '0;
    cacheBus.mem_rdata = '0; cacheBus.mem_ack = 1'b0;
    reset = 1'b0;

    vecs[0]  = mk("load 0x40 miss",          1, 0, 32'h040, 0,            0, 5, 32'h0000_00A0, 4, 0, 32'h040);
    vecs[1]  = mk("load 0x48 hit",           1, 0, 32'h048, 0,            0, 0, 32'h0000_00A2, 0, 0, 0);
    vecs[2]  = mk("store 0x44 hit 3rd ack",  0, 1, 32'h044, 32'hDEADBEEF, 2, 4, 0,             0, 1, 32'h044);
    vecs[3]  = mk("load 0x44 hit",           1, 0, 32'h044, 0,            0, 0, 32'hDEADBEEF,  0, 0, 0);
    vecs[4]  = mk("store 0x100 miss",        0, 1, 32'h100, 32'h12345678, 0, 2, 0,             0, 1, 32'h100);
    vecs[5]  = mk("load 0x100 miss",         1, 0, 32'h100, 0,            0, 5, 32'h12345678,  4, 0, 32'h100);
    vecs[6]  = mk("load 0x104 hit",          1, 0, 32'h104, 0,            0, 0, 32'h0000_01A1, 0, 0, 0);
    vecs[7]  = mk("load 0x440 conflict",     1, 0, 32'h440, 0,            1, 9, 32'h0000_04A0, 4, 0, 32'h440);
    vecs[8]  = mk("load 0x44C hit",          1, 0, 32'h44C, 0,            0, 0, 32'h0000_04A3, 0, 0, 0);
    vecs[9]  = mk("load 0x40 refill",        1, 0, 32'h040, 0,            0, 5, 32'h0000_00A0, 4, 0, 32'h040);
    vecs[10] = mk("load 0x44 after refill",  1, 0, 32'h044, 0,            0, 0, 32'hDEADBEEF,  0, 0, 0);
    vecs[11] = mk("rmem+wmem store 0x48",    1, 1, 32'h048, 32'hCAFEF00D, 0, 2, 0,             0, 1, 32'h048);
    vecs[12] = mk("load 0x48 updated",       1, 0, 32'h048, 0,            0, 0, 32'hCAFEF00D,  0, 0, 0);
    vecs[13] = mk("store 0x200 no alloc",    0, 1, 32'h200, 32'h55AA55AA, 0, 2, 0,             0, 1, 32'h200);
    vecs[14] = mk("load 0x100 still cached", 1, 0, 32'h100, 0,            0, 0, 32'h12345678,  0, 0, 0);
    vecs[15] = mk("load 0x200 miss",         1, 0, 32'h200, 0,            0, 5, 32'h55AA55AA,  4, 0, 32'h200);
    vecs[16] = mk("load 0x4A low bits",      1, 0, 32'h04A, 0,            0, 0, 32'hCAFEF00D,  0, 0, 0);
    vecs[17] = mk("load 0x440 evict",        1, 0, 32'h440, 0,            0, 5, 32'h0000_04A0, 4, 0, 32'h440);

    @(negedge clock);
    @(negedge clock);
    #1;
    checkVal("reset mem_req", 32'(cacheBus.mem_req), 32'd0);
    checkVal("reset mem_we", 32'(cacheBus.mem_we), 32'd0);
    checkVal("reset mem_addr", cacheBus.mem_addr, 32'd0);
    checkVal("reset mem_wdata", cacheBus.mem_wdata, 32'd0);
    checkVal("reset stall", 32'(cacheBus.stall), 32'd0);
    checkVal("reset rdata", cacheBus.rdata, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 18; i++) runOne(vecs[i]);

    // Line 0x40 was evicted above, so this load starts a fill that reset cuts after two acks.
    ackCnt = 0;
    cacheBus.addr = 32'h040; cacheBus.rmem = 1'b1; cacheBus.wmem = 1'b0;
    for (int c = 0; c < 20 && ackCnt < 2; c++) begin
      #1;
      cacheBus.mem_ack = cacheBus.mem_req;
      if (cacheBus.mem_req) begin
        cacheBus.mem_rdata = memRead(cacheBus.mem_addr);
        ackCnt++;
      end
      @(posedge clock);
      @(negedge clock);
    end
    cacheBus.mem_ack = 1'b0;
    checkVal("mid-fill acks", ackCnt, 32'd2);
    #1;
    checkVal("mid-fill mem_req before reset", 32'(cacheBus.mem_req), 32'd1);
    checkVal("mid-fill mem_addr before reset", cacheBus.mem_addr, 32'h048);
    reset = 1'b0;
    #1;
    checkVal("mid-fill reset mem_req", 32'(cacheBus.mem_req), 32'd0);
    checkVal("mid-fill reset mem_addr", cacheBus.mem_addr, 32'd0);
    cacheBus.rmem = 1'b0;
    #1;
    checkVal("mid-fill reset idle stall", 32'(cacheBus.stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    cacheBus.mem_ack = 1'b1;
    cacheBus.mem_rdata = 32'hBAD0BAD0;
    @(posedge clock);
    @(negedge clock);
    cacheBus.mem_ack = 1'b0;
    #1;
    checkVal("late ack mem_req", 32'(cacheBus.mem_req), 32'd0);
    checkVal("late ack stall", 32'(cacheBus.stall), 32'd0);
    @(negedge clock);

    runOne(mk("reload 0x40 after reset",   1, 0, 32'h040, 0, 0, 5, 32'h0000_00A0, 4, 0, 32'h040));
    runOne(mk("load 0x4C after reload",    1, 0, 32'h04C, 0, 0, 0, 32'h0000_00A3, 0, 0, 0));
    runOne(mk("load 0x100 invalidated",    1, 0, 32'h100, 0, 0, 5, 32'h12345678,  4, 0, 32'h100));

`ifdef DCACHE_STATS_EN
    reset = 1'b0;
    @(negedge clock);
    #1;
    checkVal("stats reset hit_count", hitCount, 32'd0);
    checkVal("stats reset miss_count", missCount, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    runOne(mk("stats miss 0x80",  1, 0, 32'h080, 0,            0, 5, 32'h0000_00A0, 4, 0, 32'h080));
    runOne(mk("stats hit 0x84",   1, 0, 32'h084, 0,            0, 0, 32'h0000_00A1, 0, 0, 0));
    runOne(mk("stats hit 0x88",   1, 0, 32'h088, 0,            0, 0, 32'h0000_00A2, 0, 0, 0));
    runOne(mk("stats store 0x80", 0, 1, 32'h080, 32'h0BADF00D, 0, 2, 0,             0, 1, 32'h080));
    runOne(mk("stats miss 0x880", 1, 0, 32'h880, 0,            0, 5, 32'h0000_08A0, 4, 0, 32'h880));
    #1;
    checkVal("stats hit_count", hitCount, 32'd2);
    checkVal("stats miss_count", missCount, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
